// File: rtl/ula_pkg.sv
// ula_pkg: shared types and flag bit positions for the ULA issue/retire stage
//   state_t : issue/retire FSM states (IDLE, EXEC, RESP)
//   FLG_*   : bit positions of Z/N/C/V inside the 4-bit flag vectors
package ula_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;
endpackage

// File: rtl/ula_flag_reg.sv
// ula_flag_reg: architectural {Z,N,C,V} register with commit/clear priority
//   clk, rst_n : clock, asynchronous active-low reset
//   commit     : load d this edge (wins over clr)
//   clr        : synchronous clear when no commit
//   d          : flags from the ULA
//   q          : architectural flags
module ula_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       commit,
    input  logic       clr,
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      q <= '0;
        else if (commit) q <= d;
        else if (clr)    q <= '0;
endmodule

// File: rtl/ula_exec_stage.sv
// ula_exec_stage: valid/ready issue/retire stage around the external combinational ULA
//   req_*     : request handshake, operands, opcode, carry-chain select
//   alu_*     : registered operands to the ULA and its result/flags back
//   rsp_*     : response handshake, captured result and {Z,N,C,V}
//   flag_q    : architectural flags; C feeds the next op's carry-in when req_use_c
//   clr_flags : synchronous flag clear (loses to a same-edge commit)
//   ops_done  : wrapping retired-op counter
module ula_exec_stage
    import ula_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic              req_use_c,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_r,
    output logic [3:0]        rsp_flags,
    output logic [3:0]        flag_q,
    input  logic              clr_flags,
    output logic [CNT_W-1:0]  ops_done
);
    state_t state, state_nx;
    logic accept, commit;
    logic [3:0] alu_flags;

    assign alu_flags = {alu_z, alu_n, alu_c, alu_v};
    assign commit    = state == EXEC;
    assign rsp_valid = state == RESP;
    assign req_ready = state == IDLE || (state == RESP && rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = req_valid ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Carry-in samples flag_q at accept; on a back-to-back accept this is
    // the value committed by the previous op's EXEC edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_cin    <= 1'b0;
        end else if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= req_opcode;
            alu_cin    <= req_use_c & flag_q[FLG_C];
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_r     <= '0;
            rsp_flags <= '0;
            ops_done  <= '0;
        end else if (commit) begin
            rsp_r     <= alu_r;
            rsp_flags <= alu_flags;
            ops_done  <= ops_done + CNT_W'(1);
        end

    ula_flag_reg u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .commit (commit),
        .clr    (clr_flags),
        .d      (alu_flags),
        .q      (flag_q)
    );
endmodule

// File: tb/tb_ula_exec_stage.sv
// tb_ula_exec_stage: directed checks of ula_exec_stage driving a small ULA model (0=ADD, 1=SUB)
module tb_ula_exec_stage;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_use_c;
    logic [7:0]  req_a, req_b;
    logic [4:0]  req_opcode;
    logic [7:0]  alu_a, alu_b, alu_r;
    logic [4:0]  alu_opcode;
    logic        alu_cin, alu_z, alu_n, alu_c, alu_v;
    logic        rsp_valid, rsp_ready, clr_flags;
    logic [7:0]  rsp_r;
    logic [3:0]  rsp_flags, flag_q;
    logic [15:0] ops_done;
    logic [8:0]  sum;
    int n_cmp = 0;
    int n_bad = 0;

    ula_exec_stage dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_use_c(req_use_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_r(alu_r), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_flags(rsp_flags),
        .flag_q(flag_q), .clr_flags(clr_flags), .ops_done(ops_done)
    );

    always_comb begin
        sum   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (alu_opcode == 5'd0) begin
            sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
            alu_r = sum[7:0];
            alu_c = sum[8];
            alu_v = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
        end else if (alu_opcode == 5'd1) begin
            sum   = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
            alu_r = sum[7:0];
            alu_c = sum[8];
            alu_v = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
        end
        alu_z = (alu_opcode <= 5'd1) && (alu_r == 8'h00);
        alu_n = alu_r[7];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op, input logic uc);
        req_a = a; req_b = b; req_opcode = op; req_use_c = uc; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic retire;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 0; req_a = 0; req_b = 0; req_opcode = 0; req_use_c = 0;
        rsp_ready = 0; clr_flags = 0;
        step(); step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (flag_q !== 4'h0) begin n_bad++; $display("FAIL reset_flag_q got %h want 0", flag_q); end
        n_cmp++; if (ops_done !== 16'd0) begin n_bad++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
        n_cmp++; if ({alu_a, alu_b, alu_opcode, alu_cin} !== 22'd0) begin n_bad++; $display("FAIL reset_alu got %h/%h/%h/%b want 0", alu_a, alu_b, alu_opcode, alu_cin); end
        n_cmp++; if ({rsp_r, rsp_flags} !== 12'd0) begin n_bad++; $display("FAIL reset_rsp got %h/%h want 0", rsp_r, rsp_flags); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_add_basic;
        issue(8'h0F, 8'h01, 5'd0, 1'b0);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_lat_early got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready got %b want 0", req_ready); end
        n_cmp++; if (alu_a !== 8'h0F || alu_b !== 8'h01 || alu_cin !== 1'b0) begin n_bad++; $display("FAIL add_alu_in got %h %h %b want 0f 01 0", alu_a, alu_b, alu_cin); end
        step();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_lat got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_r !== 8'h10 || rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL add_rsp got %h %b want 10 0000", rsp_r, rsp_flags); end
        n_cmp++; if (ops_done !== 16'd1) begin n_bad++; $display("FAIL add_ops got %0d want 1", ops_done); end
        retire();
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL add_idle got %b %b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_ops;
        issue(8'h05, 8'h07, 5'd1, 1'b0);
        step();
        n_cmp++; if (rsp_r !== 8'hFE || rsp_flags !== 4'b0110) begin n_bad++; $display("FAIL sub_rsp got %h %b want fe 0110", rsp_r, rsp_flags); end
        n_cmp++; if (flag_q !== 4'b0110) begin n_bad++; $display("FAIL sub_flag_q got %b want 0110", flag_q); end
        retire();
        issue(8'h12, 8'h34, 5'h1F, 1'b0);
        step();
        n_cmp++; if (rsp_r !== 8'h00 || rsp_flags !== 4'b0000 || ops_done !== 16'd3) begin n_bad++; $display("FAIL unimpl_rsp got %h %b %0d want 00 0000 3", rsp_r, rsp_flags, ops_done); end
        retire();
    endtask

    task automatic test_carry_chain;
        issue(8'hFF, 8'h01, 5'd0, 1'b0);
        step();
        n_cmp++; if (rsp_r !== 8'h00 || rsp_flags !== 4'b1010) begin n_bad++; $display("FAIL chain1_rsp got %h %b want 00 1010", rsp_r, rsp_flags); end
        n_cmp++; if (flag_q !== 4'b1010) begin n_bad++; $display("FAIL chain1_flag_q got %b want 1010", flag_q); end
        rsp_ready = 1'b1;
        issue(8'h00, 8'h00, 5'd0, 1'b1);
        rsp_ready = 1'b0;
        n_cmp++; if (alu_cin !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL chain2_cin got %b %b want 1 0", alu_cin, rsp_valid); end
        step();
        n_cmp++; if (rsp_r !== 8'h01 || rsp_flags !== 4'b0000 || flag_q !== 4'b0000) begin n_bad++; $display("FAIL chain2_rsp got %h %b %b want 01 0000 0000", rsp_r, rsp_flags, flag_q); end
    endtask

    task automatic test_stall;
        req_a = 8'h55; req_b = 8'h11; req_opcode = 5'd0; req_use_c = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hs[%0d] got %b %b want 1 0", i, rsp_valid, req_ready); end
            n_cmp++; if (rsp_r !== 8'h01 || rsp_flags !== 4'b0000 || alu_a !== 8'h00 || ops_done !== 16'd5) begin n_bad++; $display("FAIL stall_hold[%0d] got %h %b %h %0d want 01 0000 00 5", i, rsp_r, rsp_flags, alu_a, ops_done); end
        end
        req_valid = 1'b0;
        retire();
    endtask

    task automatic test_back_to_back;
        req_a = 8'h01; req_b = 8'h01; req_opcode = 5'd0; req_use_c = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        repeat (8) step();
        req_valid = 1'b0;
        n_cmp++; if (ops_done !== 16'd9 || rsp_r !== 8'h02) begin n_bad++; $display("FAIL b2b_ops got %0d %h want 9 02", ops_done, rsp_r); end
        step();
        rsp_ready = 1'b0;
        n_cmp++; if (ops_done !== 16'd9 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %0d %b want 9 0", ops_done, rsp_valid); end
    endtask

    task automatic test_clr_flags;
        issue(8'hFF, 8'h01, 5'd0, 1'b0);
        clr_flags = 1'b1;
        step();
        n_cmp++; if (flag_q !== 4'b1010) begin n_bad++; $display("FAIL clr_commit_wins got %b want 1010", flag_q); end
        step();
        n_cmp++; if (flag_q !== 4'b0000) begin n_bad++; $display("FAIL clr_resp got %b want 0000", flag_q); end
        n_cmp++; if (rsp_flags !== 4'b1010 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL clr_rsp_kept got %b %b want 1010 1", rsp_flags, rsp_valid); end
        clr_flags = 1'b0;
        retire();
    endtask

    task automatic test_reset_mid;
        issue(8'hFF, 8'h01, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || flag_q !== 4'h0 || ops_done !== 16'd0) begin n_bad++; $display("FAIL rstmid_state got %b %b %0d want 0 0 0", rsp_valid, flag_q, ops_done); end
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || flag_q !== 4'h0) begin n_bad++; $display("FAIL rstmid_idle got %b %b %b want 1 0 0", req_ready, rsp_valid, flag_q); end
        issue(8'h0F, 8'h01, 5'd0, 1'b1);
        n_cmp++; if (alu_a !== 8'h0F || alu_cin !== 1'b0) begin n_bad++; $display("FAIL rstmid_accept got %h %b want 0f 0", alu_a, alu_cin); end
        step();
        n_cmp++; if (rsp_r !== 8'h10 || ops_done !== 16'd1) begin n_bad++; $display("FAIL rstmid_rsp got %h %0d want 10 1", rsp_r, ops_done); end
        retire();
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_ops();
        test_carry_chain();
        test_stall();
        test_back_to_back();
        test_clr_flags();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
